sysarr_out_collector: RTL and testbench

Output-side deserializer for the systolic array. It accepts one DW-bit result element per cycle from an array output lane and assembles N consecutive elements into a row. Completed rows are presented as a single N*DW-bit word over a valid/ready handshake to the writeback path. It is double-buffered, so one row can fill while the previous row waits to drain. It is the mirror of the per-lane input FIFO, which loads N values in parallel and shifts them out one per cycle.

---
 rtl/sys_arr_pkg.sv | 13 +
 rtl/sysarr_out_collector.sv | 115 +++++++++++
 tb/tb_sysarr_out_collector.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_arr_pkg.sv
// Shared systolic-array parameters and types.
// Row type and fill-count width used by the output collector.
package sys_arr_pkg;

    localparam int unsigned N          = 4;
    localparam int unsigned DW         = 16;
    localparam int unsigned COLLECT_IW = $clog2(N);
    localparam int unsigned COLLECT_CW = $clog2(N) + 1;

    typedef logic [N*DW-1:0] sysarr_row_t;
    typedef logic [DW-1:0]   sysarr_elem_t;

endpackage

// File: rtl/sysarr_out_collector.sv
// Output-side deserializer: assembles N serial result elements into one row, double-buffered.
// Optional sticky drop flag enabled by defining SYSARR_COLLECT_OVF_EN.
module sysarr_out_collector
    import sys_arr_pkg::*;
(
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output sysarr_row_t           out_data,
`ifdef SYSARR_COLLECT_OVF_EN
    output logic                  overflow,
    input  logic                  ovf_clr,
`endif
    output logic [COLLECT_CW-1:0] fill_cnt
);

    sysarr_elem_t          mem_q [2][N];
    sysarr_elem_t          mem_d [2][N];
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [COLLECT_IW-1:0] wr_idx_q, wr_idx_d;
    logic                  accept;
    logic                  drain;

    // Accept and drain are judged on registered bank_full only, so an element
    // aimed at a bank that is draining this same cycle is still dropped.
    always_comb begin
        mem_d       = mem_q;
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        accept      = in_valid && !bank_full_q[wr_bank_q];
        drain       = bank_full_q[rd_bank_q] && out_ready;

        if (accept) begin
            mem_d[wr_bank_q][wr_idx_q] = in_data;
            if (wr_idx_q == COLLECT_IW'(N - 1)) begin
                wr_idx_d               = '0;
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + COLLECT_IW'(1);
            end
        end

        if (drain) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < N; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
        end else begin
            mem_q       <= mem_d;
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
        end
    end

`ifdef SYSARR_COLLECT_OVF_EN
    logic overflow_q, overflow_d;

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (in_valid && bank_full_q[wr_bank_q]) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

    // Element 0 sits at the MSBs of the row.
    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            out_data[(N-1-i)*DW +: DW] = mem_q[rd_bank_q][i];
        end
    end

    assign out_valid = bank_full_q[rd_bank_q];
    assign in_ready  = !bank_full_q[wr_bank_q];
    assign fill_cnt  = {1'b0, wr_idx_q};

endmodule

// File: tb/tb_sysarr_out_collector.sv
// Self-checking bench for sysarr_out_collector: directed table, corner sequences, random vs. a row-queue model.
// Overflow checks are compiled in when SYSARR_COLLECT_OVF_EN is defined.
module tb_sysarr_out_collector;
    import sys_arr_pkg::*;

    logic                  clk = 1'b0;
    logic                  nRST = 1'b1;
    logic                  in_valid = 1'b0;
    logic [DW-1:0]         in_data = '0;
    logic                  out_ready = 1'b0;
    logic                  ovf_clr = 1'b0;
    logic                  in_ready;
    logic                  out_valid;
    sysarr_row_t           out_data;
    logic [COLLECT_CW-1:0] fill_cnt;
`ifdef SYSARR_COLLECT_OVF_EN
    logic                  overflow;
`endif

    sysarr_out_collector dut (
        .clk       (clk),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SYSARR_COLLECT_OVF_EN
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
`endif
        .fill_cnt  (fill_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: completed rows waiting to drain (at most two), plus the partial row.
    sysarr_row_t  m_rows[$];
    sysarr_elem_t m_part[$];
    logic         m_ovf = 1'b0;
    sysarr_row_t  dut_rows[$];

    typedef struct {
        logic                  v;
        logic [DW-1:0]         d;
        logic                  r;
        logic                  eov;
        logic                  eir;
        logic [COLLECT_CW-1:0] efc;
        sysarr_row_t           edata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_clock();
        bit drop;
        bit drn;
        sysarr_row_t row;
        drop = in_valid && (m_rows.size() == 2);
        drn  = out_ready && (m_rows.size() > 0);
        if (drn) void'(m_rows.pop_front());
        if (in_valid && !drop) begin
            m_part.push_back(in_data);
            if (m_part.size() == N) begin
                row = '0;
                foreach (m_part[k]) row = (row << DW) | sysarr_row_t'(m_part[k]);
                m_rows.push_back(row);
                m_part.delete();
            end
        end
        if (drop)         m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic step(input string tag);
        if (out_valid && out_ready) dut_rows.push_back(out_data);
        @(posedge clk);
        model_clock();
        #1;
        chk({tag, " out_valid"}, 64'(out_valid), 64'(m_rows.size() > 0));
        chk({tag, " in_ready"},  64'(in_ready),  64'(m_rows.size() < 2));
        chk({tag, " fill_cnt"},  64'(fill_cnt),  64'(m_part.size()));
        if (m_rows.size() > 0) chk({tag, " out_data"}, out_data, m_rows[0]);
`ifdef SYSARR_COLLECT_OVF_EN
        chk({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
`endif
    endtask

    task automatic do_reset(input string tag);
        nRST      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        m_rows.delete();
        m_part.delete();
        m_ovf = 1'b0;
        #1;
        chk({tag, " rst out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " rst in_ready"},  64'(in_ready),  64'd1);
        chk({tag, " rst fill_cnt"},  64'(fill_cnt),  64'd0);
        chk({tag, " rst out_data"},  out_data,       64'd0);
`ifdef SYSARR_COLLECT_OVF_EN
        chk({tag, " rst overflow"}, 64'(overflow), 64'd0);
`endif
        @(negedge clk);
        nRST = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] d, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        step(tag);
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 3'd1, 64'h0};
        vecs[1] = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 3'd2, 64'h0};
        vecs[2] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 3'd3, 64'h0};
        vecs[3] = '{1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 3'd0, 64'h0001_0002_0003_0004};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd0, 64'h0001_0002_0003_0004};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, 64'h0};

        #2;
        do_reset("init");

        foreach (vecs[k]) begin
            in_valid  = vecs[k].v;
            in_data   = vecs[k].d;
            out_ready = vecs[k].r;
            step("vec");
            chk("vec out_valid exp", 64'(out_valid), 64'(vecs[k].eov));
            chk("vec in_ready exp",  64'(in_ready),  64'(vecs[k].eir));
            chk("vec fill_cnt exp",  64'(fill_cnt),  64'(vecs[k].efc));
            if (vecs[k].eov) chk("vec out_data exp", out_data, vecs[k].edata);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Two back-to-back rows with the consumer always ready.
        dut_rows.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(16'h0010 + 16'(i), "stream8");
        step("stream8 idle");
        step("stream8 idle");
        chk("stream8 row count", 64'(dut_rows.size()), 64'd2);
        if (dut_rows.size() == 2) begin
            chk("stream8 row0", dut_rows[0], 64'h0010_0011_0012_0013);
            chk("stream8 row1", dut_rows[1], 64'h0014_0015_0016_0017);
        end

        // Fill both banks, then drop the 9th element.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'h0020 + 16'(i), "fill9");
        chk("both full in_ready", 64'(in_ready), 64'd0);
        chk("both full out_valid", 64'(out_valid), 64'd1);
        send(16'h0028, "fill9 drop");
        chk("drop fill_cnt", 64'(fill_cnt), 64'd0);
        chk("drop out_data", out_data, 64'h0020_0021_0022_0023);
`ifdef SYSARR_COLLECT_OVF_EN
        chk("drop overflow set", 64'(overflow), 64'd1);
`endif
        ovf_clr = 1'b1;
        step("ovf_clr");
        ovf_clr = 1'b0;
`ifdef SYSARR_COLLECT_OVF_EN
        chk("overflow cleared", 64'(overflow), 64'd0);
`endif

        // Element arriving while its target bank drains is still dropped.
        dut_rows.delete();
        out_ready = 1'b1;
        send(16'hDEAD, "same-cycle drain");
        chk("sc drop fill_cnt", 64'(fill_cnt), 64'd0);
        chk("sc in_ready", 64'(in_ready), 64'd1);
        chk("sc next row", out_data, 64'h0024_0025_0026_0027);
        out_ready = 1'b0;
        send(16'h0030, "sc next");
        chk("sc next fill_cnt", 64'(fill_cnt), 64'd1);
        for (int i = 1; i < 4; i++) send(16'h0030 + 16'(i), "sc rest");
        out_ready = 1'b1;
        step("sc drain");
        step("sc drain");
        step("sc drain");
        chk("sc row count", 64'(dut_rows.size()), 64'd3);
        if (dut_rows.size() == 3) begin
            chk("sc row0", dut_rows[0], 64'h0020_0021_0022_0023);
            chk("sc row1", dut_rows[1], 64'h0024_0025_0026_0027);
            chk("sc row2", dut_rows[2], 64'h0030_0031_0032_0033);
        end

        // Reset after a partial row, then assemble a fresh one.
        out_ready = 1'b0;
        send(16'h0040, "midrow");
        send(16'h0041, "midrow");
        do_reset("midrow");
        dut_rows.delete();
        for (int i = 0; i < 4; i++) send(16'h0050 + 16'(i), "post-reset");
        chk("post-reset out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step("post-reset drain");
        chk("post-reset row count", 64'(dut_rows.size()), 64'd1);
        if (dut_rows.size() == 1) chk("post-reset row", dut_rows[0], 64'h0050_0051_0052_0053);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
